// File: rtl/mem_port_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding and timeout default.
package mem_port_arb_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StBusy0 = 2'b01,
        StBusy1 = 2'b10
    } arb_state_e;

    localparam int unsigned TmoDefault = 15;

endpackage

// File: rtl/mem_port_arb_if.sv
// Bundle of the two requester ports plus the shared memory-side signals.
interface mem_port_arb_if #(
    parameter int unsigned N = 16
);

    // requester side
    logic         req0;
    logic         req1;
    logic         wr0;
    logic         wr1;
    logic [N-1:0] addr0;
    logic [N-1:0] addr1;
    logic [N-1:0] wdata0;
    logic [N-1:0] wdata1;
    logic         gnt0;
    logic         gnt1;
    logic         done0;
    logic         done1;
    logic         err0;
    logic         err1;
    logic [N-1:0] rdata;
    logic         sel;

    // memory side
    logic         mem_done;
    logic [N-1:0] mem_rdata;
    logic         mem_en;
    logic         mem_wr;
    logic [N-1:0] mem_addr;
    logic [N-1:0] mem_wdata;

    // arbiter view
    modport slave (
        input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, mem_done, mem_rdata,
        output gnt0, gnt1, done0, done1, err0, err1, rdata, sel,
        output mem_en, mem_wr, mem_addr, mem_wdata
    );

    // requester / memory-model view
    modport master (
        output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, mem_done, mem_rdata,
        input  gnt0, gnt1, done0, done1, err0, err1, rdata, sel,
        input  mem_en, mem_wr, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_port_arb_mux2_1_16b.sv
// Plain 2:1 multiplexer, width-parameterised; i_sel=1 selects i_b.
module mux2_1_16b #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_sel,
    output logic [W-1:0] o_y
);

    assign o_y = i_sel ? i_b : i_a;

endmodule

// File: rtl/mem_port_arb.sv
// Two-port memory arbiter: round-robin on ties, per-transaction mem_done timeout.
module mem_port_arb
    import mem_port_arb_pkg::*;
#(
    parameter int unsigned N   = 16,
    parameter int unsigned TMO = TmoDefault
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    mem_port_arb_if.slave   bus
);

    localparam logic [7:0] TmoCnt = 8'(TMO);

    arb_state_e r_state_q;
    arb_state_e w_state_d;
    logic       r_last_q;   // port granted most recently; reset to 1 so port 0 wins first tie
    logic       w_last_d;
    logic [7:0] r_cnt_q;
    logic [7:0] w_cnt_d;
    logic       w_done0;
    logic       w_done1;
    logic       w_err0;
    logic       w_err1;
    logic       w_sel;

    // State, last-grant and timeout registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state_q <= StIdle;
            r_last_q  <= 1'b1;
            r_cnt_q   <= 8'd0;
        end else begin
            r_state_q <= w_state_d;
            r_last_q  <= w_last_d;
            r_cnt_q   <= w_cnt_d;
        end
    end

    // Next-state, completion and timeout decode
    always_comb begin
        w_state_d = r_state_q;
        w_last_d  = r_last_q;
        w_cnt_d   = r_cnt_q;
        w_done0   = 1'b0;
        w_done1   = 1'b0;
        w_err0    = 1'b0;
        w_err1    = 1'b0;
        unique case (r_state_q)
            StIdle: begin
                // mem_done is ignored here
                if (bus.req0 && (!bus.req1 || r_last_q)) begin
                    w_state_d = StBusy0;
                    w_last_d  = 1'b0;
                    w_cnt_d   = 8'd0;
                end else if (bus.req1) begin
                    w_state_d = StBusy1;
                    w_last_d  = 1'b1;
                    w_cnt_d   = 8'd0;
                end
            end
            StBusy0: begin
                // completion takes priority over a coincident timeout
                if (bus.mem_done) begin
                    w_done0   = 1'b1;
                    w_state_d = StIdle;
                end else if (r_cnt_q == TmoCnt) begin
                    w_err0    = 1'b1;
                    w_state_d = StIdle;
                end else begin
                    w_cnt_d = r_cnt_q + 8'd1;
                end
            end
            StBusy1: begin
                if (bus.mem_done) begin
                    w_done1   = 1'b1;
                    w_state_d = StIdle;
                end else if (r_cnt_q == TmoCnt) begin
                    w_err1    = 1'b1;
                    w_state_d = StIdle;
                end else begin
                    w_cnt_d = r_cnt_q + 8'd1;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    assign w_sel     = (r_state_q == StBusy1);
    assign bus.gnt0  = (r_state_q == StBusy0);
    assign bus.gnt1  = (r_state_q == StBusy1);
    assign bus.mem_en = (r_state_q == StBusy0) || (r_state_q == StBusy1);
    assign bus.sel   = w_sel;
    assign bus.done0 = w_done0;
    assign bus.done1 = w_done1;
    assign bus.err0  = w_err0;
    assign bus.err1  = w_err1;
    assign bus.rdata = bus.mem_rdata;

    mux2_1_16b #(.W(N)) u_mux_addr (
        .i_a   (bus.addr0),
        .i_b   (bus.addr1),
        .i_sel (w_sel),
        .o_y   (bus.mem_addr)
    );

    mux2_1_16b #(.W(N)) u_mux_wdata (
        .i_a   (bus.wdata0),
        .i_b   (bus.wdata1),
        .i_sel (w_sel),
        .o_y   (bus.mem_wdata)
    );

    mux2_1_16b #(.W(1)) u_mux_wr (
        .i_a   (bus.wr0),
        .i_b   (bus.wr1),
        .i_sel (w_sel),
        .o_y   (bus.mem_wr)
    );

endmodule

// File: doc/mem_port_arb.md
MEM_PORT_ARB -- requirements
Module: mem_port_arb

Interface
REQ-001 Parameter N, default 16, data/address width in bits.
REQ-002 Parameter TMO, default 15, mem_done timeout in cycles (1..255).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req0 / req1  input  1  level request from port 0 (fetch) / port 1 (data); held until doneX or errX.
REQ-006 wr0 / wr1  input  1  1 = write, 0 = read; held stable with reqX.
REQ-007 addr0 / addr1  input  N  request address; held stable with reqX.
REQ-008 wdata0 / wdata1  input  N  write data; held stable with reqX.
REQ-009 mem_done  input  1  one-cycle pulse from memory, transaction complete.
REQ-010 mem_rdata  input  N  read data, valid when mem_done=1.
REQ-011 gnt0 / gnt1  output  1  registered grant, one-hot or zero.
REQ-012 done0 / done1  output  1  completion pulse to granted port.
REQ-013 err0 / err1  output  1  timeout pulse to granted port.
REQ-014 rdata  output  N  mem_rdata passthrough.
REQ-015 mem_en  output  1  memory access strobe.
REQ-016 mem_wr, mem_addr[N], mem_wdata[N]  output  muxed from granted port.
REQ-017 sel  output  1  mux select, 0 = port 0, 1 = port 1.

Function
REQ-018 FSM states IDLE, BUSY0, BUSY1; encoding 2 bits.
REQ-019 IDLE, no req: stay IDLE.
REQ-020 IDLE, single reqX: next state BUSYX.
REQ-021 IDLE, both req: grant port not equal to last; last updates on every grant.
REQ-022 gntX = 1 exactly while state == BUSYX; mem_en = gnt0 | gnt1.
REQ-023 sel = 1 in BUSY1, 0 otherwise (holds 0 in IDLE).
REQ-024 mem_addr/mem_wr/mem_wdata = 2:1 mux of port 0/port 1 fields under sel; no registering, zero latency.
REQ-025 doneX = mem_done & (state == BUSYX), combinational, same cycle.
REQ-026 mem_done in IDLE: ignored, no doneX, no state change.
REQ-027 BUSYX with mem_done: next state IDLE; minimum one IDLE cycle between transactions.
REQ-028 Timeout counter, 8 bits, cleared on entering BUSYX, increments each BUSYX cycle without mem_done.
REQ-029 Counter == TMO with no mem_done: errX pulses one cycle, next state IDLE, no doneX.
REQ-030 mem_done and timeout in the same cycle: mem_done wins, doneX asserted, errX not asserted.
REQ-031 reqX dropped while BUSYX (protocol violation): transaction continues to done or timeout.
REQ-032 Minimum grant latency: reqX high at edge k in IDLE -> gntX high after edge k.

Reset
REQ-033 rst_n low: state=IDLE, last=1 (port 0 wins first tie), counter=0, immediately, independent of clk.
REQ-034 During reset: gnt0=gnt1=0, done/err=0, mem_en=0, sel=0.
REQ-035 Reset mid-transaction aborts silently; no doneX or errX generated.
REQ-036 Deassertion of rst_n is synchronous to clk at the system level; first grant possible at the first edge after deassertion.

Structure
REQ-037 Shared package holds the FSM state encodings (IDLE=2'b00, BUSY0=2'b01, BUSY1=2'b10) and the default TMO value.
REQ-038 Three instances of mux2_1_16b: address (N), write data (N), mem_wr (N=1), all driven by sel.
REQ-039 FSM, last-grant flop, and timeout counter live in mem_port_arb; no other sub-modules.

Verification
REQ-040 Reset then req0=1, addr0=0x1234, wr0=0; mem_done at 3rd BUSY0 cycle -> gnt0 for 3 cycles, mem_addr=0x1234, done0 pulse, rdata=mem_rdata.
REQ-041 req0=req1=1 from reset, each serviced by 2-cycle mem_done -> grants alternate 0,1,0,1 with one IDLE cycle between.
REQ-042 req1=1, wr1=1, wdata1=0xBEEF, no mem_done -> err1 pulses on 16th BUSY1 cycle (TMO=15), state IDLE, done1 never asserted.
REQ-043 mem_done on the same cycle as counter == TMO -> done1=1, err1=0.
REQ-044 rst_n low mid-BUSY0 -> gnt0, mem_en drop without clk edge; next tie grants port 0.
REQ-045 mem_done pulse in IDLE -> no done0/done1, state unchanged.
